// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, with a 2-flop input synchronizer and an
// AXI-Stream style byte output; framing errors and overruns are 1-cycle pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_tdata,
    output logic       rx_tvalid,
    input  logic       rx_tready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_e;

    state_e        state_q, state_d;
    logic          rx_meta_q, rx_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!rx_s_q) state_d = START;
            START: if (cnt_q == HALF_LAST) state_d = rx_s_q ? IDLE : DATA;
            DATA:  if (cnt_q == BIT_LAST && idx_q == 3'd7) state_d = STOP;
            STOP:  if (cnt_q == BIT_LAST) state_d = rx_s_q ? IDLE : BREAK;
            BREAK: if (rx_s_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q & ~rx_tready;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;
        case (state_q)
            IDLE, BREAK: begin
                cnt_d = '0;
                idx_d = 3'd0;
            end
            START: begin
                cnt_d = (cnt_q == HALF_LAST) ? '0 : cnt_q + CW'(1);
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q != 3'd7) idx_d = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    // A slot freed by acceptance this very cycle can take the new byte.
                    if (!rx_s_q) begin
                        ferr_d = 1'b1;
                    end else if (!tvalid_q || rx_tready) begin
                        tdata_d  = shift_q;
                        tvalid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d = '0;
                idx_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            shift_q  <= 8'd0;
            tdata_q  <= 8'd0;
            tvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign rx_tdata      = tdata_q;
    assign rx_tvalid     = tvalid_q;
    assign framing_error = ferr_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: frames are driven on rxd,
// expected bytes are queued and checked as the consumer accepts them.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic [7:0] rx_tdata;
    logic       rx_tvalid;
    logic       rx_tready;
    logic       framing_error;
    logic       overrun;

    int         checkCount = 0;
    int         errorCount = 0;
    int         cycle = 0;
    int         ferrCount = 0;
    int         ovrCount = 0;
    int         acceptCycle = 0;
    int         frameStartCycle = 0;
    int         latency;
    logic [7:0] expQ[$];
    logic [7:0] expByte;
    logic [7:0] prevData = 8'd0;
    logic       prevStall = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .reset         (reset),
        .rxd           (rxd),
        .rx_tdata      (rx_tdata),
        .rx_tvalid     (rx_tvalid),
        .rx_tready     (rx_tready),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs always change 1 time unit after a rising edge.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        frameStartCycle = cycle;
        rxd = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            waitCycles(CPB);
        end
        rxd = stopBit;
        waitCycles(CPB);
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 400 && expQ.size() != 0; i++) waitCycles(1);
        checkOutput(tag, expQ.size(), 0);
    endtask

    // Consumer-side monitor: pulse counting, stall stability and scoreboard pops.
    always @(negedge clk) begin
        if (framing_error) ferrCount++;
        if (overrun) ovrCount++;
        if (framing_error && overrun) checkOutput("err overlap", 1, 0);
        if (prevStall) begin
            checkOutput("hold valid", 32'(rx_tvalid), 1);
            checkOutput("hold data", 32'(rx_tdata), 32'(prevData));
        end
        if (rx_tvalid && rx_tready) begin
            acceptCycle = cycle;
            if (expQ.size() == 0) begin
                checkOutput("unexpected byte", 32'(rx_tdata), 32'h100);
            end else begin
                expByte = expQ.pop_front();
                checkOutput("rx byte", 32'(rx_tdata), 32'(expByte));
            end
        end
        prevStall = rx_tvalid && !rx_tready;
        prevData  = rx_tdata;
    end

    initial begin
        reset     = 1'b0;
        rxd       = 1'b1;
        rx_tready = 1'b1;
        waitCycles(3);
        checkOutput("reset tdata", 32'(rx_tdata), 0);
        checkOutput("reset tvalid", 32'(rx_tvalid), 0);
        checkOutput("reset ferr", 32'(framing_error), 0);
        checkOutput("reset ovr", 32'(overrun), 0);
        reset = 1'b1;
        waitCycles(10);

        // Single byte, latency from falling edge to rx_tvalid.
        expQ.push_back(8'hA5);
        applyStimulus(8'hA5, 1'b1);
        waitDrain("a5 drain");
        latency = acceptCycle - frameStartCycle;
        checkOutput("latency in 153..155", 32'(latency >= 153 && latency <= 155), 1);
        checkOutput("a5 no ferr", ferrCount, 0);
        checkOutput("a5 no ovr", ovrCount, 0);
        waitCycles(10);

        // Short low glitch is rejected by the start-bit midpoint check.
        rxd = 1'b0;
        waitCycles(4);
        rxd = 1'b1;
        waitCycles(40);
        checkOutput("glitch tvalid", 32'(rx_tvalid), 0);
        checkOutput("glitch ferr", ferrCount, 0);

        // Bad stop bit then a long break, followed by a good frame.
        applyStimulus(8'h3C, 1'b0);
        waitCycles(100);
        checkOutput("break ferr count", ferrCount, 1);
        checkOutput("break tvalid", 32'(rx_tvalid), 0);
        rxd = 1'b1;
        waitCycles(20);
        expQ.push_back(8'h81);
        applyStimulus(8'h81, 1'b1);
        waitDrain("81 drain");
        waitCycles(10);

        // Consumer stalled: second byte overruns and is dropped.
        rx_tready = 1'b0;
        expQ.push_back(8'h11);
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        waitCycles(10);
        checkOutput("stall tvalid", 32'(rx_tvalid), 1);
        checkOutput("stall tdata", 32'(rx_tdata), 32'h11);
        checkOutput("overrun count", ovrCount, 1);
        rx_tready = 1'b1;
        waitDrain("11 drain");
        waitCycles(3);
        checkOutput("after accept tvalid", 32'(rx_tvalid), 0);
        checkOutput("ferr total", ferrCount, 1);
        waitCycles(10);

        // Back-to-back frames with no idle time between stop and start.
        expQ.push_back(8'h00);
        expQ.push_back(8'hFF);
        expQ.push_back(8'h55);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h55, 1'b1);
        waitDrain("b2b drain");
        waitCycles(10);

        // Reset in the middle of the data bits of 0x77.
        rxd = 1'b0;
        waitCycles(CPB);
        rxd = 1'b1;
        waitCycles(CPB);
        waitCycles(8);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("midreset tdata", 32'(rx_tdata), 0);
        checkOutput("midreset tvalid", 32'(rx_tvalid), 0);
        checkOutput("midreset ferr", 32'(framing_error), 0);
        checkOutput("midreset ovr", 32'(overrun), 0);
        waitCycles(3);
        rxd = 1'b1;
        waitCycles(5);
        reset = 1'b1;
        waitCycles(30);
        expQ.push_back(8'h5A);
        applyStimulus(8'h5A, 1'b1);
        waitDrain("5a drain");
        waitCycles(20);
        checkOutput("final ferr total", ferrCount, 1);
        checkOutput("final ovr total", ovrCount, 1);
        checkOutput("final tvalid", 32'(rx_tvalid), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
